// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the sliced logic unit.
// Opcode and state encodings, plus an elaboration-time configuration check.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    LU_AND  = 3'd0,
    LU_OR   = 3'd1,
    LU_XOR  = 3'd2,
    LU_NOT  = 3'd3,
    LU_NAND = 3'd4,
    LU_NOR  = 3'd5,
    LU_XNOR = 3'd6,
    LU_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The operand width must split into a whole number (>= 1) of slices.
  function automatic bit slice_cfg_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator on one SLICE-bit chunk of the operands.
// Operand b is not used by NOT A and PASS A.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  op_e              op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  // Select the bitwise function for the current opcode.
  always_comb begin
    y = '0;
    case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      LU_NOT:  y = ~a;
      LU_NAND: y = ~(a & b);
      LU_NOR:  y = ~(a | b);
      LU_XNOR: y = ~(a ^ b);
      LU_PASS: y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit operands processed SLICE bits per
// cycle, LSB slice first, with valid/ready handshakes on both sides.
// Optional feature macro: LOGIC_UNIT_PARITY_EN (enables the parity flag;
// otherwise parity is tied low). The port list is the same in both builds.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_bad_cfg
      $error("logic_unit_seq: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  state_e           state;
  logic [IDX_W-1:0] idx;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] a_arr [NSLICE];
  logic [SLICE-1:0] b_arr [NSLICE];
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] y_sl;
  logic [WIDTH-1:0] result_next;
  logic             last;
  logic             accept;

  // Split the latched operands into slices so idx can pick one through a mux.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_split
      assign a_arr[gi] = a_q[gi*SLICE +: SLICE];
      assign b_arr[gi] = b_q[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_sl   = a_arr[idx];
  assign b_sl   = b_arr[idx];
  assign last   = (idx == IDX_W'(NSLICE - 1));
  assign accept = (state == IDLE) && in_valid && in_ready;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op (op_q),
    .a  (a_sl),
    .b  (b_sl),
    .y  (y_sl)
  );

  // Merge the freshly computed slice into the result at position idx.
  always_comb begin
    result_next = result;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx == IDX_W'(i)) begin
        result_next[i*SLICE +: SLICE] = y_sl;
      end
    end
  end

  // Control FSM with registered handshake outputs, result and zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      op_q      <= LU_AND;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= RUN;
            op_q     <= op_e'(op);
            a_q      <= data_a;
            b_q      <= data_b;
            idx      <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          result <= result_next;
          if (last) begin
            state     <= DONE;
            idx       <= '0;
            zero      <= (result_next == '0);
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Result and flags stay frozen until the consumer takes them.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic par_acc;
  logic par_next;

  assign par_next = par_acc ^ (^y_sl);

  // Accumulate parity slice by slice; publish it together with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      parity  <= 1'b0;
    end else if (accept) begin
      par_acc <= 1'b0;
    end else if (state == RUN) begin
      par_acc <= par_next;
      if (last) begin
        parity <= par_next;
      end
    end
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq (16/4 build plus an 8/8 build).
module tb_logic_unit_seq;

`ifdef LOGIC_UNIT_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [15:0] data_a = '0;
  logic [15:0] data_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        zero;
  logic        parity;
  logic        busy;

  // single-slice instance (WIDTH=8, SLICE=8)
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  data_a8 = '0;
  logic [7:0]  data_b8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  result8;
  logic        zero8;
  logic        parity8;
  logic        busy8;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity), .busy(busy)
  );

  logic_unit_seq #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .data_a(data_a8), .data_b(data_b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .zero(zero8), .parity(parity8), .busy(busy8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait for its acceptance, then count cycles until out_valid.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    int w;
    op = o; data_a = a; data_b = b; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    n_checks++;
    if ({in_ready, out_valid, result, zero, parity, busy} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b res=%h z=%b p=%b busy=%b, required 1 0 0000 0 0 0",
               in_ready, out_valid, result, zero, parity, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset: rdy=%b vld=%b res=%h busy=%b", in_ready, out_valid, result, busy);
  endtask

  task automatic test_and();
    int lat;
    out_ready = 1'b1;
    run_op(3'd0, 16'hF0F0, 16'hFF00, lat);
    $display("and: lat=%0d res=%h z=%b p=%b", lat, result, zero, parity);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL and_latency: got %0d, required 4", lat); end
    n_checks++;
    if (result !== 16'hF000 || zero !== 1'b0 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL and_result: res=%h z=%b p=%b, required F000 0 0", result, zero, parity);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL and_handshake: vld=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_xor_zero();
    int lat;
    out_ready = 1'b1;
    run_op(3'd2, 16'hAAAA, 16'hAAAA, lat);
    $display("xor: lat=%0d res=%h z=%b p=%b", lat, result, zero, parity);
    n_checks++;
    if (result !== 16'h0000 || zero !== 1'b1 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL xor_zero: res=%h z=%b p=%b, required 0000 1 0", result, zero, parity);
    end
    tick();
  endtask

  task automatic test_all_ops();
    logic [15:0] exp_tab [8];
    int lat;
    // A=F0F0, B=CCCC
    exp_tab = '{16'hC0C0, 16'hFCFC, 16'h3C3C, 16'h0F0F, 16'h3F3F, 16'h0303, 16'hC3C3, 16'hF0F0};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      run_op(3'(k), 16'hF0F0, 16'hCCCC, lat);
      $display("op%0d: res=%h z=%b p=%b", k, result, zero, parity);
      n_checks++;
      if (result !== exp_tab[k] || zero !== 1'b0 || parity !== (PEN & (^exp_tab[k]))) begin
        n_fail++;
        $display("FAIL op%0d: res=%h z=%b p=%b, required %h 0 %b", k, result, zero, parity,
                 exp_tab[k], PEN & (^exp_tab[k]));
      end
      tick();
    end
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1'b0;
    run_op(3'd3, 16'h1234, 16'h5555, lat);
    in_valid = 1'b1; op = 3'd1; data_a = 16'hFFFF; data_b = 16'hFFFF;
    tick(); tick(); tick();
    $display("hold: res=%h rdy=%b vld=%b p=%b", result, in_ready, out_valid, parity);
    n_checks++;
    if (result !== 16'hEDCB || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 ||
        zero !== 1'b0 || parity !== PEN) begin
      n_fail++;
      $display("FAIL hold: res=%h rdy=%b vld=%b busy=%b z=%b p=%b, required EDCB 0 1 1 0 %b",
               result, in_ready, out_valid, busy, zero, parity, PEN);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: rdy=%b vld=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_abort();
    int lat;
    out_ready = 1'b1;
    op = 3'd1; data_a = 16'hFFFF; data_b = 16'hFFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();  // two slices written, idx now 2
    $display("abort: pre-reset res=%h busy=%b", result, busy);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || result !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort: vld=%b res=%h busy=%b rdy=%b, required 0 0000 0 1",
               out_valid, result, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(3'd1, 16'h0001, 16'h0002, lat);
    $display("abort: next op res=%h lat=%0d", result, lat);
    n_checks++;
    if (result !== 16'h0003 || lat != 4) begin
      n_fail++;
      $display("FAIL abort_next: res=%h lat=%0d, required 0003 4", result, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    op = 3'd4; data_a = 16'hFFFF; data_b = 16'hFFFF; in_valid = 1'b1;
    tick();  // NAND accepted
    op = 3'd6; data_a = 16'h00FF; data_b = 16'h0F0F;
    w = 0;
    while (!out_valid && w < 50) begin tick(); w++; end
    $display("b2b first: res=%h z=%b lat=%0d", result, zero, w);
    n_checks++;
    if (result !== 16'h0000 || zero !== 1'b1 || w != 4) begin
      n_fail++;
      $display("FAIL b2b_first: res=%h z=%b lat=%0d, required 0000 1 4", result, zero, w);
    end
    tick();  // output handshake edge
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
    end
    tick();  // second accept exactly one cycle after the handshake
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b rdy=%b, required 1 0", busy, in_ready);
    end
    w = 0;
    while (!out_valid && w < 50) begin tick(); w++; end
    // 0x00FF XNOR 0x0F0F = ~0x0FF0 = 0xF00F
    $display("b2b second: res=%h z=%b lat=%0d", result, zero, w);
    n_checks++;
    if (result !== 16'hF00F || zero !== 1'b0 || w != 4) begin
      n_fail++;
      $display("FAIL b2b_second: res=%h z=%b lat=%0d, required F00F 0 4", result, zero, w);
    end
    tick();
  endtask

  task automatic test_parity();
    int lat;
    out_ready = 1'b1;
    run_op(3'd7, 16'h0007, 16'hFFFF, lat);
    $display("parity 0007: res=%h p=%b", result, parity);
    n_checks++;
    if (result !== 16'h0007 || parity !== PEN) begin
      n_fail++;
      $display("FAIL parity_odd: res=%h p=%b, required 0007 %b", result, parity, PEN);
    end
    tick();
    run_op(3'd7, 16'h0003, 16'h1111, lat);
    $display("parity 0003: res=%h p=%b", result, parity);
    n_checks++;
    if (result !== 16'h0003 || parity !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_even: res=%h p=%b, required 0003 0", result, parity);
    end
    tick();
  endtask

  task automatic test_single_slice();
    int lat;
    int w;
    out_ready8 = 1'b1;
    op8 = 3'd0; data_a8 = 8'hF0; data_b8 = 8'h3C; in_valid8 = 1'b1;
    w = 0;
    while (!in_ready8 && w < 50) begin tick(); w++; end
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin tick(); lat++; end
    $display("slice1: lat=%0d res=%h z=%b p=%b", lat, result8, zero8, parity8);
    n_checks++;
    if (lat != 1 || result8 !== 8'h30 || zero8 !== 1'b0 || parity8 !== 1'b0) begin
      n_fail++;
      $display("FAIL slice1: lat=%0d res=%h z=%b p=%b, required 1 30 0 0", lat, result8, zero8, parity8);
    end
    tick();
    n_checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL slice1_handshake: rdy=%b vld=%b, required 1 0", in_ready8, out_valid8);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_zero();
    test_all_ops();
    test_hold();
    test_abort();
    test_back_to_back();
    test_parity();
    test_single_slice();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
